// File: rtl/pe_config_sequencer.sv
// Context-playback sequencer: holds a small program of PE configuration words
// and drives them one per entry, each for its programmed number of cycles.
module pe_config_sequencer #(
  parameter int CFG_W = 22,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CFG_W-1:0] wr_cfg,
  input  logic [3:0]       wr_hold,
  input  logic [AW:0]      ctx_count,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [CFG_W-1:0] configuration,
  output logic             cfg_valid,
  output logic [AW-1:0]    ctx_index,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t           r_state;
  logic [CFG_W-1:0] r_cfg_mem  [DEPTH];
  logic [3:0]       r_hold_mem [DEPTH];
  logic [AW:0]      r_count;
  logic [3:0]       r_hold_cnt;

  logic             w_we;
  logic             w_start;
  logic [AW:0]      w_count_clamped;
  logic [AW:0]      w_next_idx_ext;
  logic [AW-1:0]    w_next_idx;
  logic [CFG_W-1:0] w_first_cfg;
  logic [3:0]       w_first_hold;

  assign wr_ready        = (r_state == S_IDLE);
  assign busy            = (r_state == S_RUN);
  assign w_we            = wr_valid && wr_ready;
  assign w_start         = (r_state == S_IDLE) && start && (ctx_count != '0);
  assign w_count_clamped = (ctx_count > DEPTH_C) ? DEPTH_C : ctx_count;
  assign w_next_idx_ext  = {1'b0, ctx_index} + (AW+1)'(1);
  assign w_next_idx      = w_next_idx_ext[AW-1:0];

  // A write to entry 0 in the start cycle must be visible to the first load.
  assign w_first_cfg  = (w_we && (wr_addr == '0)) ? wr_cfg  : r_cfg_mem[0];
  assign w_first_hold = (w_we && (wr_addr == '0)) ? wr_hold : r_hold_mem[0];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_cfg_mem[i]  <= '0;
        r_hold_mem[i] <= '0;
      end else if (w_we && (wr_addr == AW'(i))) begin
        r_cfg_mem[i]  <= wr_cfg;
        r_hold_mem[i] <= wr_hold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_hold_cnt    <= '0;
      configuration <= '0;
      cfg_valid     <= 1'b0;
      ctx_index     <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state       <= S_RUN;
            r_count       <= w_count_clamped;
            ctx_index     <= '0;
            configuration <= w_first_cfg;
            r_hold_cnt    <= w_first_hold;
            cfg_valid     <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state       <= S_IDLE;
            configuration <= '0;
            cfg_valid     <= 1'b0;
            ctx_index     <= '0;
            r_hold_cnt    <= '0;
          end else if (r_hold_cnt != 4'd0) begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end else if (w_next_idx_ext < r_count) begin
            ctx_index     <= w_next_idx;
            configuration <= r_cfg_mem[w_next_idx];
            r_hold_cnt    <= r_hold_mem[w_next_idx];
          end else if (loop_en) begin
            ctx_index     <= '0;
            configuration <= r_cfg_mem[0];
            r_hold_cnt    <= r_hold_mem[0];
          end else begin
            r_state       <= S_IDLE;
            configuration <= '0;
            cfg_valid     <= 1'b0;
            ctx_index     <= '0;
            done          <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_config_sequencer.md
PE_CONFIG_SEQUENCER -- requirements
Module: pe_config_sequencer

Parameters
REQ-001 SHALL have parameter CFG_W, default 22, width of the PE configuration word.
REQ-002 SHALL have parameter DEPTH, default 16, number of context entries.
REQ-003 SHALL have parameter AW, default 4, context address width (log2 DEPTH).

Interface
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_valid  input  1  host context-write request.
REQ-007 wr_ready  output  1  sequencer can accept a write.
REQ-008 wr_addr  input  AW  context entry index.
REQ-009 wr_cfg  input  CFG_W  configuration word to store.
REQ-010 wr_hold  input  4  extra hold cycles for this entry (entry lasts wr_hold+1 cycles).
REQ-011 ctx_count  input  AW+1  number of entries to play, sampled on start.
REQ-012 start  input  1  begin playback.
REQ-013 stop  input  1  abort playback.
REQ-014 loop_en  input  1  replay from entry 0 after last entry.
REQ-015 configuration  output  CFG_W  registered word driven to PE configuration port.
REQ-016 cfg_valid  output  1  configuration holds a live context.
REQ-017 ctx_index  output  AW  index of the entry currently driven.
REQ-018 busy  output  1  high in RUN.
REQ-019 done  output  1  one-cycle pulse on natural completion.

Function
REQ-020 SHALL hold DEPTH entries of {hold[3:0], cfg[CFG_W-1:0]} in flops.
REQ-021 SHALL implement states IDLE and RUN; busy=1 exactly in RUN.
REQ-022 wr_ready SHALL be 1 in IDLE and 0 in RUN; entry wr_addr written at the edge where wr_valid&&wr_ready.
REQ-023 In IDLE, start=1 with ctx_count>=1 SHALL latch count (values >DEPTH clamp to DEPTH) and enter RUN; start with ctx_count=0 SHALL be ignored.
REQ-024 Write and start in the same IDLE cycle SHALL both take effect; playback SHALL use the newly written data.
REQ-025 At the edge accepting start, configuration SHALL load entry 0 cfg, cfg_valid=1, ctx_index=0.
REQ-026 Each entry SHALL be driven for exactly hold+1 consecutive cycles, then entry index+1 SHALL load with no gap.
REQ-027 After the last entry's final cycle: loop_en=1 (sampled that cycle) SHALL load entry 0 with no gap; loop_en=0 SHALL return to IDLE with cfg_valid=0, configuration=0, done=1 for that one cycle.
REQ-028 stop=1 in RUN SHALL, at next edge, enter IDLE with cfg_valid=0, configuration=0, done=0; stop in IDLE SHALL be ignored.
REQ-029 start in RUN SHALL be ignored; start and stop together in IDLE SHALL start.
REQ-030 configuration SHALL be 0 whenever cfg_valid=0; ctx_index SHALL be 0 in IDLE.
REQ-031 Hold counter SHALL count down from hold to 0; no wrap or underflow beyond that.

Reset
REQ-032 rst=1 SHALL, at the edge, force IDLE, configuration=0, cfg_valid=0, ctx_index=0, busy=0, done=0, clear all entries to 0; wr_ready=1 in the following cycle.
REQ-033 rst SHALL override start, stop and write in the same cycle, including mid-RUN.

Verification
REQ-034 Reset: hold rst 2 cycles -> configuration=0, cfg_valid=0, busy=0, done=0, wr_ready=1.
REQ-035 Write e0={0,0x000F0}, e1={2,0x3F320}, e2={0,0x0000F}; ctx_count=3, start -> cfg_valid 5 cycles: 0x000F0 x1, 0x3F320 x3, 0x0000F x1, then done pulse, busy=0.
REQ-036 Same program, loop_en=1 -> 0x000F0 follows 0x0000F with no gap; drop loop_en during pass 2 -> ends after 0x0000F of that pass with done.
REQ-037 stop in 2nd cycle of e1 -> next cycle cfg_valid=0, configuration=0, done=0, wr_ready=1.
REQ-038 wr_valid during RUN to addr 0 -> wr_ready=0, rerun still shows 0x000F0; ctx_count=0 start -> stays IDLE; ctx_count=20 -> 16 entries played.
REQ-039 rst mid-RUN -> outputs 0 next cycle; rerun with ctx_count=1 shows configuration=0 with cfg_valid=1 for 1 cycle.
